// File: rtl/alu.sv
// Integer execute unit: 8/16/32/64-bit ALU with z/n/c/sn flags; MUL built only when ALU_MUL_EN is defined.
// Latency 1: inputs sampled with in_valid appear on result/flags the same edge, out_valid follows in_valid.
// No backpressure: accepts one op per cycle; outputs hold their last value while in_valid is low.
module alu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      opcode,
  input  logic [1:0]      arg_size,
  input  logic [XLEN-1:0] arg0,
  input  logic [XLEN-1:0] arg1,
  input  logic            carry,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            z,
  output logic            n,
  output logic            c,
  output logic            sn,
  output logic            illegal
);

  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_ADD = 8'd1;
  localparam logic [7:0] OP_SUB = 8'd2;
  localparam logic [7:0] OP_MUL = 8'd3;
  localparam logic [7:0] OP_ADC = 8'd4;
  localparam logic [7:0] OP_SBC = 8'd5;
  localparam logic [7:0] OP_AND = 8'd6;
  localparam logic [7:0] OP_OR  = 8'd7;
  localparam logic [7:0] OP_XOR = 8'd8;
  localparam logic [7:0] OP_NOT = 8'd9;
  localparam logic [7:0] OP_SHL = 8'd10;
  localparam logic [7:0] OP_SHR = 8'd11;
  localparam logic [7:0] OP_SAR = 8'd12;

  logic [6:0]  w;
  logic [5:0]  wm1;
  logic [63:0] mask;

  always_comb begin
    w    = 7'd64;
    wm1  = 6'd63;
    mask = '1;
    case (arg_size)
      2'd0: begin w = 7'd8;  wm1 = 6'd7;  mask = 64'h0000_0000_0000_00FF; end
      2'd1: begin w = 7'd16; wm1 = 6'd15; mask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin w = 7'd32; wm1 = 6'd31; mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin w = 7'd64; wm1 = 6'd63; mask = '1; end
    endcase
  end

  logic [63:0] a, b, sxa;
  logic        sa, sb;
  logic [5:0]  amt;

  assign a   = arg0 & mask;
  assign b   = arg1 & mask;
  assign sa  = a[wm1];
  assign sb  = b[wm1];
  assign sxa = a | (sa ? ~mask : 64'd0);
  assign amt = arg1[5:0] & wm1;

  // Carry/borrow is whatever lands above bit W-1 of the masked operands.
  logic        addc, subc;
  logic [64:0] sum, diff;

  assign addc = (opcode == OP_ADC) & carry;
  assign subc = (opcode == OP_SBC) & carry;
  assign sum  = {1'b0, a} + {1'b0, b} + {64'd0, addc};
  assign diff = {1'b0, a} - {1'b0, b} - {64'd0, subc};

  // Shifts carry one extra bit so the last bit shifted out falls out for free.
  logic [127:0] shl_w;
  logic         shl_cout;
  logic [64:0]  shr_w, sar_w;

  assign shl_w    = {64'd0, a} << amt;
  assign shl_cout = ((shl_w >> w) & 128'd1) != 128'd0;
  assign shr_w    = {a, 1'b0} >> amt;
  assign sar_w    = $signed({sxa, 1'b0}) >>> amt;

`ifdef ALU_MUL_EN
  logic [63:0]         sxb, mul_lo, mul_sx;
  logic [127:0]        pu;
  logic signed [127:0] ps;
  logic                mul_hi, mul_ovf;

  assign sxb     = b | (sb ? ~mask : 64'd0);
  assign pu      = {64'd0, a} * {64'd0, b};
  assign ps      = $signed({{64{sxa[63]}}, sxa}) * $signed({{64{sxb[63]}}, sxb});
  assign mul_lo  = pu[63:0] & mask;
  assign mul_sx  = mul_lo | (mul_lo[wm1] ? ~mask : 64'd0);
  assign mul_hi  = (pu >> w) != 128'd0;
  assign mul_ovf = $signed({{64{mul_sx[63]}}, mul_sx}) != ps;
`endif

  logic [63:0] r;
  logic        fc, fs, ill, flag_en;

  always_comb begin
    r       = '0;
    fc      = 1'b0;
    fs      = 1'b0;
    ill     = 1'b0;
    flag_en = 1'b1;
    case (opcode)
      OP_NOP: flag_en = 1'b0;
      OP_ADD, OP_ADC: begin
        r  = sum[63:0] & mask;
        fc = |(sum >> w);
        fs = (sa == sb) && (r[wm1] != sa);
      end
      OP_SUB, OP_SBC: begin
        r  = diff[63:0] & mask;
        fc = |(diff >> w);
        fs = (sa != sb) && (r[wm1] != sa);
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        r  = mul_lo;
        fc = mul_hi;
        fs = mul_ovf;
      end
`endif
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a & mask;
      OP_SHL: begin
        r  = shl_w[63:0] & mask;
        fc = shl_cout;
      end
      OP_SHR: begin
        r  = shr_w[64:1];
        fc = shr_w[0];
      end
      OP_SAR: begin
        r  = sar_w[64:1] & mask;
        fc = sar_w[0];
      end
      default: begin
        flag_en = 1'b0;
        ill     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      sn        <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result  <= r;
        z       <= flag_en && (r == 64'd0);
        n       <= flag_en && r[63];
        c       <= fc;
        sn      <= fs;
        illegal <= ill;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: arithmetic reference model plus hand-computed literal checks.
module tb_alu;

  localparam logic [7:0] NOP = 8'd0,  ADD = 8'd1,  SUB = 8'd2,  MUL = 8'd3,  ADC = 8'd4;
  localparam logic [7:0] SBC = 8'd5,  AND = 8'd6,  OR  = 8'd7,  XOR = 8'd8,  NOT = 8'd9;
  localparam logic [7:0] SHL = 8'd10, SHR = 8'd11, SAR = 8'd12;

  logic        clk = 1'b0;
  logic        reset, in_valid, carry;
  logic [7:0]  opcode;
  logic [1:0]  arg_size;
  logic [63:0] arg0, arg1;
  logic        out_valid, z, n, c, sn, illegal;
  logic [63:0] result;

  always #5 clk = ~clk;

  alu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .arg_size(arg_size),
    .arg0(arg0), .arg1(arg1), .carry(carry), .out_valid(out_valid), .result(result),
    .z(z), .n(n), .c(c), .sn(sn), .illegal(illegal)
  );

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  logic [63:0] pend_r, exp_r;
  logic        pend_z, pend_n, pend_c, pend_s, pend_i;
  logic        exp_v, exp_z, exp_n, exp_c, exp_s, exp_i;

  // Reference: exact integer arithmetic at width W, range checks for signed overflow,
  // bit-at-a-time shifting.
  task automatic model(input logic [7:0] op, input logic [1:0] sz, input logic [63:0] a0, a1,
                       input logic ci, output logic [63:0] r, output logic fz, fn, fc, fs, fi);
    int W, amt;
    logic [129:0] M, A, B, full, cur, cv, t;
    logic signed [129:0] sA, sB, sR, lo, hi;
    logic impl;
    W = 8 << sz;
    M = 130'd1 << W;
    A = {66'd0, a0} % M;
    B = {66'd0, a1} % M;
    sA = $signed(A);
    if (A >= (M >> 1)) sA = sA - $signed(M);
    sB = $signed(B);
    if (B >= (M >> 1)) sB = sB - $signed(M);
    lo = -$signed(M >> 1);
    hi = $signed(M >> 1) - 130'sd1;
    cv = (ci && (op == ADC || op == SBC)) ? 130'd1 : 130'd0;
    full = '0; sR = '0; fc = 1'b0; fs = 1'b0; fi = 1'b0; impl = 1'b1; cur = A; amt = 0;
    case (op)
      NOP: impl = 1'b0;
      ADD, ADC: begin
        full = A + B + cv;
        fc = full >= M;
        sR = sA + sB + $signed(cv);
        fs = (sR < lo) || (sR > hi);
      end
      SUB, SBC: begin
        full = A - B - cv;
        fc = A < (B + cv);
        sR = sA - sB - $signed(cv);
        fs = (sR < lo) || (sR > hi);
      end
      MUL: begin
`ifdef ALU_MUL_EN
        full = A * B;
        fc = full >= M;
        sR = sA * sB;
        fs = (sR < lo) || (sR > hi);
`else
        impl = 1'b0;
        fi = 1'b1;
`endif
      end
      AND: full = A & B;
      OR:  full = A | B;
      XOR: full = A ^ B;
      NOT: full = ~A;
      SHL, SHR, SAR: begin
        t = B % W;
        amt = int'(t[6:0]);
        for (int i = 0; i < amt; i++) begin
          if (op == SHL) begin
            fc = cur[W-1];
            cur = (cur << 1) % M;
          end else begin
            fc = cur[0];
            cur = (cur >> 1) | ((op == SAR && cur[W-1]) ? (M >> 1) : 130'd0);
          end
        end
        full = cur;
      end
      default: begin
        impl = 1'b0;
        fi = 1'b1;
      end
    endcase
    t = impl ? (full % M) : 130'd0;
    r = t[63:0];
    fz = impl && (r == 64'd0);
    fn = impl && r[63];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_v <= 1'b0; exp_r <= '0; exp_z <= 1'b0; exp_n <= 1'b0;
      exp_c <= 1'b0; exp_s <= 1'b0; exp_i <= 1'b0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        exp_r <= pend_r; exp_z <= pend_z; exp_n <= pend_n;
        exp_c <= pend_c; exp_s <= pend_s; exp_i <= pend_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({out_valid, result, z, n, c, sn, illegal} !==
          {exp_v, exp_r, exp_z, exp_n, exp_c, exp_s, exp_i}) begin
        miscompares++;
        $display("FAIL model t=%0t: got v=%b r=%h z%b n%b c%b sn%b ill%b want v=%b r=%h z%b n%b c%b sn%b ill%b",
                 $time, out_valid, result, z, n, c, sn, illegal,
                 exp_v, exp_r, exp_z, exp_n, exp_c, exp_s, exp_i);
      end
    end
  end

  task automatic drive(input logic [7:0] op, input logic [1:0] sz, input logic [63:0] a0, a1,
                       input logic ci);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; arg_size = sz; arg0 = a0; arg1 = a1; carry = ci;
    model(op, sz, a0, a1, ci, pend_r, pend_z, pend_n, pend_c, pend_s, pend_i);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; opcode = ADD; arg0 = {$urandom, $urandom}; arg1 = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic ev, input logic [63:0] er,
                     input logic ez, en, ec, es, ei);
    vectors++;
    if ({out_valid, result, z, n, c, sn, illegal} !== {ev, er, ez, en, ec, es, ei}) begin
      miscompares++;
      $display("FAIL %s: got v=%b r=%h z%b n%b c%b sn%b ill%b want v=%b r=%h z%b n%b c%b sn%b ill%b",
               name, out_valid, result, z, n, c, sn, illegal, ev, er, ez, en, ec, es, ei);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = NOP; arg_size = 2'd0;
    arg0 = '0; arg1 = '0; carry = 1'b0;
    pend_r = '0; pend_z = 1'b0; pend_n = 1'b0; pend_c = 1'b0; pend_s = 1'b0; pend_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 1'b0, 64'd0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    drive(NOP, 2'd0, 64'd5, 64'd7, 1'b0); tick();
    lit("nop8", 1'b1, 64'd0, 0, 0, 0, 0, 0);
    drive(ADD, 2'd0, 64'd1, 64'd2, 1'b0); tick();
    lit("add8", 1'b1, 64'h3, 0, 0, 0, 0, 0);
    drive(SUB, 2'd0, 64'd1, 64'd2, 1'b0); tick();
    lit("sub8_borrow", 1'b1, 64'hFF, 0, 0, 1, 0, 0);
    drive(MUL, 2'd0, 64'd3, 64'd2, 1'b0); tick();
`ifdef ALU_MUL_EN
    lit("mul8", 1'b1, 64'h6, 0, 0, 0, 0, 0);
`else
    lit("mul8_off", 1'b1, 64'h0, 0, 0, 0, 0, 1);
`endif
    drive(ADD, 2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0); tick();
    lit("add64_ovf", 1'b1, 64'h8000_0000_0000_0000, 0, 1, 0, 1, 0);
    drive(ADC, 2'd0, 64'hFF, 64'd0, 1'b1); tick();
    lit("adc8_wrap", 1'b1, 64'h0, 1, 0, 1, 0, 0);
    drive(ADD, 2'd1, 64'hABCD_FFFF, 64'h1234_0001, 1'b0); tick();
    lit("add16_upper_ignored", 1'b1, 64'h0, 1, 0, 1, 0, 0);
    drive(SUB, 2'd2, 64'h8000_0000, 64'd1, 1'b0); tick();
    lit("sub32_ovf", 1'b1, 64'h7FFF_FFFF, 0, 0, 0, 1, 0);
    drive(SBC, 2'd0, 64'd0, 64'd0, 1'b1); tick();
    drive(SHL, 2'd2, 64'h8000_0001, 64'd1, 1'b0); tick();
    lit("shl32", 1'b1, 64'h2, 0, 0, 1, 0, 0);
    idle(); tick();
    lit("hold", 1'b0, 64'h2, 0, 0, 1, 0, 0);
    idle();
    drive(SHR, 2'd1, 64'hFFFF_0003, 64'd1, 1'b0); tick();
    lit("shr16", 1'b1, 64'h1, 0, 0, 1, 0, 0);
    drive(SAR, 2'd0, 64'h80, 64'd9, 1'b0); tick();
    lit("sar8_mod", 1'b1, 64'hC0, 0, 0, 0, 0, 0);
    drive(SAR, 2'd3, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
    drive(SHR, 2'd0, 64'h81, 64'd8, 1'b0); tick();
    lit("shr8_zero_amt", 1'b1, 64'h81, 0, 0, 0, 0, 0);
    drive(SHL, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'd68, 1'b0);
    drive(XOR, 2'd0, 64'hF0, 64'hFF, 1'b0); tick();
    lit("xor8", 1'b1, 64'h0F, 0, 0, 0, 0, 0);
    drive(NOT, 2'd3, 64'd0, 64'd0, 1'b1); tick();
    lit("not64", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0);
    drive(NOT, 2'd0, 64'h0F, 64'd0, 1'b0);
    drive(AND, 2'd1, 64'hFFFF_F0F0, 64'h0FF0, 1'b0);
    drive(OR, 2'd2, 64'hFFFF_0000_1200_0034, 64'h0056_0000, 1'b0);
    drive(MUL, 2'd1, 64'h100, 64'h100, 1'b0); tick();
`ifdef ALU_MUL_EN
    lit("mul16_wrap", 1'b1, 64'h0, 1, 0, 1, 1, 0);
`else
    lit("mul16_off", 1'b1, 64'h0, 0, 0, 0, 0, 1);
`endif
    drive(MUL, 2'd0, 64'hFF, 64'hFF, 1'b0);
    drive(MUL, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    drive(8'd13, 2'd0, 64'd1, 64'd1, 1'b0); tick();
    lit("undef13", 1'b1, 64'h0, 0, 0, 0, 0, 1);
    drive(8'd255, 2'd3, 64'd9, 64'd9, 1'b1);
    drive(ADD, 2'd2, 64'hFFFF_FFFF, 64'd1, 1'b0);
    drive(SUB, 2'd3, 64'd0, 64'd1, 1'b0);
    drive(ADD, 2'd0, 64'd4, 64'd4, 1'b0);
    reset = 1'b1;
    tick();
    lit("reset_wins", 1'b0, 64'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    drive(SBC, 2'd3, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
